// File: rtl/ex_mem_pkg.sv
// Shared widths and constants for the EX/MEM pipeline register.
package ex_mem_pkg;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REGS_ADDR_BUS        = 5;
  localparam int REGS_DATA_BUS        = 32;
  localparam int DOUBLE_REGS_DATA_BUS = 2 * REGS_DATA_BUS;
  localparam int CNT_BUS              = 2;

  localparam logic [REGS_DATA_BUS-1:0] ZERO_WORD = '0;

  // Controller stall vector layout; EX and MEM bits are the pair this stage uses.
  localparam int STALL_BUS     = 6;
  localparam int STALL_EX_BIT  = 3;
  localparam int STALL_MEM_BIT = 4;
endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/bubble/hold control and MADD/MSUB scratch state.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH = REGS_DATA_BUS,
  parameter int ADDR_WIDTH = REGS_ADDR_BUS,
  parameter int CNT_WIDTH  = CNT_BUS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall_ex,
  input  logic                    stall_mem,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   ex_write_addr,
  input  logic                    ex_write_enable,
  input  logic [DATA_WIDTH-1:0]   ex_write_data,
  input  logic                    ex_write_hilo_enable,
  input  logic [DATA_WIDTH-1:0]   ex_write_hi_data,
  input  logic [DATA_WIDTH-1:0]   ex_write_lo_data,
  input  logic [2*DATA_WIDTH-1:0] ex_hilo_temp,
  input  logic [CNT_WIDTH-1:0]    ex_cnt,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic                    mem_write_enable,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_write_hilo_enable,
  output logic [DATA_WIDTH-1:0]   mem_write_hi_data,
  output logic [DATA_WIDTH-1:0]   mem_write_lo_data,
  output logic [2*DATA_WIDTH-1:0] hilo_temp,
  output logic [CNT_WIDTH-1:0]    cnt,
  output logic                    mem_valid
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] data;
    logic                  hilo_we;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
  } mem_entry_t;

  mem_entry_t entry;
  mem_entry_t ex_entry;

  assign ex_entry = '{valid:   ENABLE,
                      addr:    ex_write_addr,
                      we:      ex_write_enable,
                      data:    ex_write_data,
                      hilo_we: ex_write_hilo_enable,
                      hi:      ex_write_hi_data,
                      lo:      ex_write_lo_data};

  // A bubble still captures the step-0 partial product so EX can finish the
  // accumulate on the next cycle; completing an advance retires that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry     <= '0;
      hilo_temp <= '0;
      cnt       <= '0;
    end else if (flush) begin
      entry     <= '0;
      hilo_temp <= '0;
      cnt       <= '0;
    end else if (stall_ex && !stall_mem) begin
      entry     <= '0;
      hilo_temp <= ex_hilo_temp;
      cnt       <= ex_cnt;
    end else if (!stall_ex) begin
      entry     <= ex_entry;
      hilo_temp <= '0;
      cnt       <= '0;
    end
  end

  assign mem_valid             = entry.valid;
  assign mem_write_addr        = entry.addr;
  assign mem_write_enable      = entry.we;
  assign mem_write_data        = entry.data;
  assign mem_write_hilo_enable = entry.hilo_we;
  assign mem_write_hi_data     = entry.hi;
  assign mem_write_lo_data     = entry.lo;

endmodule

// File: tb/tb_ex_mem.sv
// Directed table-driven bench for ex_mem plus async-reset corner sequences.
module tb_ex_mem;
  logic        clock = 1'b0;
  logic        reset;
  logic        stall_ex, stall_mem, flush;
  logic [4:0]  ex_write_addr;
  logic        ex_write_enable;
  logic [31:0] ex_write_data;
  logic        ex_write_hilo_enable;
  logic [31:0] ex_write_hi_data, ex_write_lo_data;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic [4:0]  mem_write_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_write_hilo_enable;
  logic [31:0] mem_write_hi_data, mem_write_lo_data;
  logic [63:0] hilo_temp;
  logic [1:0]  cnt;
  logic        mem_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem dut (
    .clock(clock), .reset(reset), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_write_addr(ex_write_addr), .ex_write_enable(ex_write_enable), .ex_write_data(ex_write_data),
    .ex_write_hilo_enable(ex_write_hilo_enable), .ex_write_hi_data(ex_write_hi_data),
    .ex_write_lo_data(ex_write_lo_data), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_write_addr(mem_write_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_write_hilo_enable(mem_write_hilo_enable),
    .mem_write_hi_data(mem_write_hi_data), .mem_write_lo_data(mem_write_lo_data),
    .hilo_temp(hilo_temp), .cnt(cnt), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (reset) assert (!(!stall_ex && stall_mem)) else $error("illegal stall_ex=0 stall_mem=1");

  typedef struct {
    string       name;
    logic        se, sm, fl;
    logic [4:0]  a;  logic we;  logic [31:0] d;
    logic        hwe; logic [31:0] hi, lo;
    logic [63:0] ht; logic [1:0] c;
    logic [4:0]  ea; logic ewe; logic [31:0] ed;
    logic        ehwe; logic [31:0] ehi, elo;
    logic [63:0] eht; logic [1:0] ec; logic ev;
  } vec_t;

  function automatic vec_t mk(string name, logic se, logic sm, logic fl,
      logic [4:0] a, logic we, logic [31:0] d, logic hwe, logic [31:0] hi, logic [31:0] lo,
      logic [63:0] ht, logic [1:0] c,
      logic [4:0] ea, logic ewe, logic [31:0] ed, logic ehwe, logic [31:0] ehi, logic [31:0] elo,
      logic [63:0] eht, logic [1:0] ec, logic ev);
    vec_t v;
    v.name = name; v.se = se; v.sm = sm; v.fl = fl;
    v.a = a; v.we = we; v.d = d; v.hwe = hwe; v.hi = hi; v.lo = lo; v.ht = ht; v.c = c;
    v.ea = ea; v.ewe = ewe; v.ed = ed; v.ehwe = ehwe; v.ehi = ehi; v.elo = elo;
    v.eht = eht; v.ec = ec; v.ev = ev;
    return v;
  endfunction

  function automatic logic [169:0] outs();
    return {mem_write_addr, mem_write_enable, mem_write_data, mem_write_hilo_enable,
            mem_write_hi_data, mem_write_lo_data, hilo_temp, cnt, mem_valid};
  endfunction

  task automatic check(input string name, input logic [169:0] act, input logic [169:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_ex = v.se; stall_mem = v.sm; flush = v.fl;
    ex_write_addr = v.a; ex_write_enable = v.we; ex_write_data = v.d;
    ex_write_hilo_enable = v.hwe; ex_write_hi_data = v.hi; ex_write_lo_data = v.lo;
    ex_hilo_temp = v.ht; ex_cnt = v.c;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    drive(v);
    @(posedge clock);
    #1;
    check(v.name, outs(), {v.ea, v.ewe, v.ed, v.ehwe, v.ehi, v.elo, v.eht, v.ec, v.ev});
  endtask

  vec_t tbl[16];
  vec_t idle, junk, bub, adv;

  initial begin
    tbl[0]  = mk("adv_first", 0,0,0, 3,1,32'h1234_5678, 0,0,0, 0,0,
                 3,1,32'h1234_5678, 0,0,0, 0,0,1);
    tbl[1]  = mk("b2b_a", 0,0,0, 1,1,32'hA, 0,0,0, 0,0,  1,1,32'hA, 0,0,0, 0,0,1);
    tbl[2]  = mk("b2b_b", 0,0,0, 2,1,32'hB, 1,32'h0BAD,32'h0CAFE, 0,0,
                 2,1,32'hB, 1,32'h0BAD,32'h0CAFE, 0,0,1);
    tbl[3]  = mk("b2b_c", 0,0,0, 3,1,32'hC, 0,32'h1,32'h2, 0,0,  3,1,32'hC, 0,32'h1,32'h2, 0,0,1);
    tbl[4]  = mk("madd_bubble", 1,0,0, 7,1,32'h77, 1,32'h5,32'h6, 64'h0000_0001_FFFF_FFFE,1,
                 0,0,0, 0,0,0, 64'h0000_0001_FFFF_FFFE,1,0);
    tbl[5]  = mk("madd_done", 0,0,0, 9,1,32'h99, 1,32'hAAAA_AAAA,32'h5555_5555, 64'hDEAD,2,
                 9,1,32'h99, 1,32'hAAAA_AAAA,32'h5555_5555, 0,0,1);
    for (int i = 0; i < 4; i++)
      tbl[6+i] = mk($sformatf("hold_%0d", i), 1,1,0, 5'(10+i),0,32'hFFFF_0000+i, 0,32'hF,32'hE,
                    64'hBEEF,2'd3,
                    9,1,32'h99, 1,32'hAAAA_AAAA,32'h5555_5555, 0,0,1);
    tbl[10] = mk("bubble2", 1,0,0, 4,1,32'h44, 0,0,0, 64'h1234,1,  0,0,0, 0,0,0, 64'h1234,1,0);
    tbl[11] = mk("flush_hold", 1,1,1, 5,1,32'h55, 1,32'h5,32'h5, 64'h9,3,  0,0,0, 0,0,0, 0,0,0);
    tbl[12] = mk("adv_after_flush", 0,0,0, 6,1,32'h66, 1,32'h7,32'h8, 0,0,
                 6,1,32'h66, 1,32'h7,32'h8, 0,0,1);
    tbl[13] = mk("flush_adv", 0,0,1, 8,1,32'h88, 1,32'h1,32'h1, 64'h1,1,  0,0,0, 0,0,0, 0,0,0);
    tbl[14] = mk("bubble3", 1,0,0, 0,0,0, 0,0,0, 64'hFFFF_FFFF_0000_0001,2,
                 0,0,0, 0,0,0, 64'hFFFF_FFFF_0000_0001,2,0);
    tbl[15] = mk("flush_bubble", 1,0,1, 2,1,32'h2, 1,32'h3,32'h4, 64'h5,1,  0,0,0, 0,0,0, 0,0,0);

    idle = mk("idle", 1,1,0, 0,0,0, 0,0,0, 0,0,  0,0,0, 0,0,0, 0,0,0);
    junk = mk("junk", 0,0,0, 31,1,32'hDEAD_BEEF, 1,32'h1111,32'h2222, 64'h3333,3,
              0,0,0, 0,0,0, 0,0,0);

    // reset asserted from time zero with nonzero inputs
    reset = 1'b0;
    drive(junk);
    #3;
    check("reset_init", outs(), '0);
    @(posedge clock); #1;
    check("reset_held_edge", outs(), '0);
    @(negedge clock);
    drive(idle);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) apply(tbl[i]);

    // async reset in the middle of a MADD sequence
    bub = mk("rst_seq_bubble", 1,0,0, 1,1,32'h1, 0,0,0, 64'hCAFE_0000_0000_BABE,1,
             0,0,0, 0,0,0, 64'hCAFE_0000_0000_BABE,1,0);
    apply(bub);
    reset = 1'b0;
    #2;
    check("rst_async_mid_madd", outs(), '0);
    @(negedge clock);
    drive(idle);
    reset = 1'b1;
    adv = mk("adv_after_reset", 0,0,0, 12,1,32'hC0DE, 1,32'h10,32'h20, 64'h77,2,
             12,1,32'hC0DE, 1,32'h10,32'h20, 0,0,1);
    apply(adv);

    // async reset with a live entry, while inputs are nonzero
    @(negedge clock);
    drive(junk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_async_live_entry", outs(), '0);
    @(negedge clock);
    drive(idle);
    reset = 1'b1;
    @(posedge clock); #1;
    check("idle_after_reset", outs(), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures EX results each cycle: GPR write-back triple plus HI/LO write triple, and presents them to MEM.
- Honours per-stage stall and flush signals from the pipeline controller.
- Holds the multi-cycle multiply-accumulate scratch state (64-bit partial product plus step counter). EX needs this state to finish MADD/MSUB over two cycles while EX is stalled.

Parameters:
DATA_WIDTH, 32, width of a GPR/HI/LO word (matches `REGS_DATA_BUS)
ADDR_WIDTH, 5, GPR address width (matches `REGS_ADDR_BUS)
CNT_WIDTH, 2, width of the multi-cycle step counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (reset asserted when 0)
stall_ex  input  1  controller holds EX this cycle
stall_mem  input  1  controller holds MEM this cycle
flush  input  1  exception/branch flush; kill the in-flight entry
ex_write_addr  input  ADDR_WIDTH  GPR destination from EX
ex_write_enable  input  1  GPR write request from EX
ex_write_data  input  DATA_WIDTH  GPR data from EX
ex_write_hilo_enable  input  1  HI/LO write request from EX
ex_write_hi_data  input  DATA_WIDTH  HI data from EX
ex_write_lo_data  input  DATA_WIDTH  LO data from EX
ex_hilo_temp  input  2*DATA_WIDTH  partial product produced by EX in step 0 of MADD/MSUB
ex_cnt  input  CNT_WIDTH  next step index from EX
mem_write_addr  output  ADDR_WIDTH  registered to MEM
mem_write_enable  output  1  registered to MEM
mem_write_data  output  DATA_WIDTH  registered to MEM
mem_write_hilo_enable  output  1  registered to MEM
mem_write_hi_data  output  DATA_WIDTH  registered to MEM
mem_write_lo_data  output  DATA_WIDTH  registered to MEM
hilo_temp  output  2*DATA_WIDTH  fed back to EX
cnt  output  CNT_WIDTH  fed back to EX
mem_valid  output  1  entry in MEM is a real instruction (not a bubble)

Behaviour:
- Reset (reset==0, asynchronous): all outputs go to 0 immediately, independent of clock; mem_valid=0. Release is sampled on the next rising edge.
- All other updates occur on the rising clock edge only. Latency is exactly 1 cycle from EX inputs to mem_* outputs.
- Priority per edge: flush > (stall_ex & ~stall_mem) > ~stall_ex > hold.
- Flush:
  - All mem_* outputs become 0, mem_valid=0, hilo_temp=0, cnt=0.
  - Flush overrides any stall combination.
- Bubble (stall_ex=1, stall_mem=0):
  - mem_write_enable=0, mem_write_hilo_enable=0; address/data fields 0; mem_valid=0.
  - hilo_temp<=ex_hilo_temp and cnt<=ex_cnt, so that EX sees its step-0 result next cycle.
- Advance (stall_ex=0):
  - All mem_* outputs take the ex_* values; mem_valid=1.
  - hilo_temp and cnt are cleared to 0, because the accumulate sequence has completed.
  - This applies regardless of stall_mem.
- Hold (stall_ex=1, stall_mem=1): every register, including hilo_temp/cnt, keeps its value.
- stall_ex=0 with stall_mem=1 is illegal from the controller. The block treats it as Advance, and the bench asserts it never occurs.
- No arithmetic in this block. hilo_temp is stored as an opaque 64-bit value. cnt does not increment locally and only mirrors ex_cnt, so wrap-around is EX's concern.
- Reset asserted mid-MADD sequence: hilo_temp/cnt clear, and EX restarts from step 0.

Decomposition:
- Shared package/macro file gets:
  - ENABLE/DISABLE and ZERO_WORD constants.
  - REGS_ADDR_BUS, REGS_DATA_BUS and DOUBLE_REGS_DATA_BUS widths.
  - A new CNT_BUS width and a named STALL_BUS index pair for the EX/MEM stall bits.
- No sub-module needed. Optionally a generic flopr_en_clr register (enable + synchronous clear) can be reused for each field group.

Test Plan:
- Reset: drive reset=0 with nonzero inputs mid-cycle -> all outputs 0 without waiting for an edge; reset=1 then one edge with ex_write_data=32'h1234_5678, ex_write_addr=5'd3, ex_write_enable=1 -> mem_write_data=32'h12345678, mem_write_addr=3, mem_valid=1.
- Back-to-back advance: three consecutive instructions (addr 1, 2, 3; data A, B, C) -> MEM sees each exactly one cycle later, in order, with no gaps.
- MADD bubble: stall_ex=1, stall_mem=0, ex_hilo_temp=64'h0000_0001_FFFF_FFFE, ex_cnt=1, ex_write_enable=1 -> mem_write_enable=0, mem_valid=0, hilo_temp=64'h00000001FFFFFFFE, cnt=1. Next edge with stall_ex=0 -> hilo_temp=0, cnt=0, EX result latched.
- Full hold: load entry (hi=32'hAAAA_AAAA, hilo enable=1), then stall_ex=stall_mem=1 for 4 cycles while inputs change -> outputs unchanged for all 4 cycles.
- Flush priority: flush=1 together with stall_ex=stall_mem=1 and cnt=1 held -> all outputs 0, cnt=0, mem_valid=0 after the edge.
- Reset mid-sequence: after the bubble sets cnt=1, pulse reset=0 for half a cycle -> cnt=0 and hilo_temp=0 immediately; the following instruction advances normally.
